fib_seq_ctrl: RTL and testbench
===============================

# fib_seq_ctrl

Synchronous sequencer that drives the asynchronous dual-rail Fibonacci datapath (`fib_tp`) without a VIO. On a `go` command it pulses the datapath reset, raises `start`, and collects a programmed number of results. For each result it runs the four-phase return-to-zero handshake on the datapath output link (`ack_i`), decodes the dual-rail word into a single-rail value, and presents it on the clocked side. It sits between the clocked test/host logic and `fib_tp`, replacing the manual `rst`/`start`/`ack_i` probes and the free-running `sync` path.

## Interface
- `WIDTH`, 16, data bits per result
- `RAIL_NUM`, 2, rails per bit; only 2 is supported; rail[1]=true, rail[0]=false
- `CNT_W`, 8, width of the result-count field
- `RST_CYCLES`, 4, cycles `dp_rst` is held high per run (≥1)
- `TIMEOUT`, 1024, watchdog limit in cycles per handshake phase
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `go`  in  1  single-cycle run command; ignored unless state is IDLE or DONE
- `count`  in  CNT_W  results to collect; sampled on accepted `go`
- `dp_rst`  out  1  datapath reset, active high
- `dp_start`  out  1  datapath start level
- `dp_ack`  out  1  drives datapath `ack_i`
- `dp_out`  in  WIDTH×RAIL_NUM  datapath dual-rail output (asynchronous)
- `result`  out  WIDTH  decoded word; holds its value between captures
- `result_valid`  out  1  one-cycle pulse per captured result
- `busy`  out  1  high from accepted `go` until DONE or ERR
- `done`  out  1  high in DONE; cleared by next accepted `go`
- `err`  out  1  high in ERR; cleared only by `rst` or next accepted `go`
- `err_code`  out  2  0 none, 1 timeout, 2 illegal code (rails 11)

## Operation
- Input path: `dp_out` passes through a 2-flop synchronizer (s1, s2), then an s3 history register.
- A sample is **stable** when s2 == s3.
- **Complete**: every bit is 01 or 10.
- **Null**: every bit is 00.
- **Illegal**: any bit is 11 in a stable sample.
- Decode: `result[i]` = rail[1] of bit i.
- FSM states:
  - **IDLE**: accept `go` and load `remaining` = `count`. If `count` == 0 → DONE; else → RESET.
  - **RESET**: `dp_rst` = 1 for RST_CYCLES cycles → RUN.
  - **RUN**: `dp_rst` = 0, `dp_start` = 1 → WAIT_VALID.
  - **WAIT_VALID**: on a stable complete sample, register `result`, pulse `result_valid`, set `dp_ack` = 1 → WAIT_NULL.
  - **WAIT_NULL**: on a stable null sample, `dp_ack` = 0 and `remaining` −1. If the new value is 0 → DONE; else → WAIT_VALID.
  - **DONE**: `dp_start` = 0, `done` = 1; `dp_rst` stays 0.
  - **ERR**: `dp_ack` = 0, `dp_start` = 0, `dp_rst` = 1.
- A stable illegal sample in WAIT_VALID or WAIT_NULL → ERR with `err_code` = 2.
- `go` in DONE or ERR behaves as in IDLE and clears `done`/`err`.
- `go` in any other state is ignored.
- `count` is sampled only on accepted `go`; later changes have no effect.
- `remaining` is CNT_W wide; `count` = 2^CNT_W−1 is legal and never wraps.

## Timing
- Reset values: `dp_rst` = 1, `dp_start` = 0, `dp_ack` = 0, `result` = 0, `result_valid` = 0, `busy` = 0, `done` = 0, `err` = 0, `err_code` = 0.
- After reset the state is IDLE.
- Asserting `rst` mid-run aborts immediately to the reset values. `dp_rst` = 1 then holds the datapath in reset.
- All outputs are registered.
- `go` at edge N → `busy` and `dp_rst` high at N+1. `dp_rst` falls and `dp_start` rises at N+1+RST_CYCLES.
- Rails settle before edge M → `result_valid` and `dp_ack` high at edge M+3: s1, s2, s3 equal, then capture.
- Null settles before edge K → `dp_ack` low at K+3.
- `result_valid` and the `dp_ack` rise share a cycle. `result` is valid from that cycle until the next capture.
- Watchdog counts from WAIT_VALID/WAIT_NULL entry. It resets on each transition between these states.

## Configuration
- `FIB_SEQ_TIMEOUT_EN`: when defined, the watchdog is compiled in. Reaching TIMEOUT cycles in WAIT_VALID or WAIT_NULL → ERR with `err_code` = 1.
- When undefined, there is no watchdog: the FSM waits indefinitely and `err_code` = 1 never occurs.

## Test plan
- Reset with `rst` = 0 → all outputs at reset values. Then `go` with `count` = 5 against the behavioural dual-rail `fib_tp` model → `result` sequence 0, 1, 1, 2, 3. Exactly 5 `result_valid` pulses, each followed by a `dp_ack` rise and fall; then `done` = 1, `dp_start` = 0.
- `go` with `count` = 0 → `done` = 1 at N+1; `dp_rst` stays 1, `dp_start` = 0, no `result_valid`.
- Model drives bit 3 = 11 during data phase → `err` = 1, `err_code` = 2, `dp_rst` = 1, `dp_ack` = 0.
- With `FIB_SEQ_TIMEOUT_EN` and TIMEOUT = 16, model never returns to null → `err_code` = 1 exactly 16 cycles after WAIT_NULL entry. Without the macro, no error after 1000 cycles.
- Assert `rst` = 0 after the 2nd result of a `count` = 5 run → outputs return to reset values. A fresh `go` with `count` = 3 yields 0, 1, 1.
- Glitchy rails (value changes each cycle for 4 cycles, then stable 0x0055) → a single capture of 0x0055 only. A `go` pulsed while `busy` is ignored.

Source files
------------

// File: rtl/fib_seq_ctrl.sv
// Clocked sequencer for the dual-rail Fibonacci datapath: reset/start, four-phase ack, decode.
// Define FIB_SEQ_TIMEOUT_EN to compile in the per-phase handshake watchdog.
module fib_seq_ctrl #(
    parameter int WIDTH      = 16,
    parameter int RAIL_NUM   = 2,
    parameter int CNT_W      = 8,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic [CNT_W-1:0]          count,
    output logic                      dp_rst,
    output logic                      dp_start,
    output logic                      dp_ack,
    input  logic [WIDTH*RAIL_NUM-1:0] dp_out,
    output logic [WIDTH-1:0]          result,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code
);
    localparam int RW   = WIDTH * RAIL_NUM;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RAIL_NUM != 2 || RST_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("fib_seq_ctrl: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUN, S_WAIT_VALID, S_WAIT_NULL, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [RW-1:0]     s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  rem_q;
    logic [RC_W-1:0]   rc_q;
    logic [WIDTH-1:0]  result_q;
    logic              dp_rst_q, dp_start_q, dp_ack_q, result_valid_q;
    logic              busy_q, done_q, err_q;
    logic [1:0]        err_code_q;

    logic [WIDTH-1:0]  t_d, f_d;
    logic              stable_d, complete_d, null_d, illegal_d;
    logic              in_wait_d, adv_d, wd_hit_d, err_hit_d;
    logic [1:0]        err_code_d;

    // Split the synchronized word into true/false rails and classify it
    always_comb begin
        t_d = '0;
        f_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_d[i] = s2_q[2*i+1];
            f_d[i] = s2_q[2*i];
        end
        stable_d   = (s2_q == s3_q);
        complete_d = &(t_d ^ f_d);
        null_d     = ~|s2_q;
        illegal_d  = stable_d && (|(t_d & f_d));
        in_wait_d  = (state_q == S_WAIT_VALID) || (state_q == S_WAIT_NULL);
        adv_d      = stable_d && (((state_q == S_WAIT_VALID) && complete_d) ||
                                  ((state_q == S_WAIT_NULL) && null_d));
        err_hit_d  = in_wait_d && (illegal_d || (!adv_d && wd_hit_d));
        err_code_d = illegal_d ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= dp_out;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

`ifdef FIB_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;

    // Restarts on every wait-state entry, since a handshake step clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else if (in_wait_d && !adv_d) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    assign wd_hit_d = (wd_q == WD_W'(TIMEOUT - 1));
`else
    assign wd_hit_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            rem_q          <= '0;
            rc_q           <= '0;
            result_q       <= '0;
            dp_rst_q       <= 1'b1;
            dp_start_q     <= 1'b0;
            dp_ack_q       <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= 2'd0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        rem_q      <= count;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= 2'd0;
                        dp_start_q <= 1'b0;
                        dp_ack_q   <= 1'b0;
                        if (count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_RESET;
                            busy_q   <= 1'b1;
                            dp_rst_q <= 1'b1;
                            rc_q     <= RC_W'(RST_CYCLES - 1);
                        end
                    end
                end
                S_RESET: begin
                    if (rc_q == '0) begin
                        dp_rst_q   <= 1'b0;
                        dp_start_q <= 1'b1;
                        state_q    <= S_RUN;
                    end else begin
                        rc_q <= rc_q - 1'b1;
                    end
                end
                S_RUN: state_q <= S_WAIT_VALID;
                S_WAIT_VALID, S_WAIT_NULL: begin
                    if (err_hit_d) begin
                        state_q    <= S_ERR;
                        err_q      <= 1'b1;
                        err_code_q <= err_code_d;
                        dp_ack_q   <= 1'b0;
                        dp_start_q <= 1'b0;
                        dp_rst_q   <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (adv_d && (state_q == S_WAIT_VALID)) begin
                        result_q       <= t_d;
                        result_valid_q <= 1'b1;
                        dp_ack_q       <= 1'b1;
                        state_q        <= S_WAIT_NULL;
                    end else if (adv_d) begin
                        dp_ack_q <= 1'b0;
                        rem_q    <= rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            dp_start_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_VALID;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dp_rst       = dp_rst_q;
    assign dp_start     = dp_start_q;
    assign dp_ack       = dp_ack_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a small dual-rail Fibonacci datapath model.
// Covers the FIB_SEQ_TIMEOUT_EN watchdog when that macro is defined.
module tb_fib_seq_ctrl;
    localparam int WIDTH      = 16;
    localparam int CNT_W      = 8;
    localparam int RST_CYCLES = 4;
    localparam int TIMEOUT    = 16;

    localparam int SIG_RV    = 0;
    localparam int SIG_ACK   = 1;
    localparam int SIG_START = 2;
    localparam int SIG_ERR   = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 go = 1'b0;
    logic [CNT_W-1:0]     count = '0;
    logic [2*WIDTH-1:0]   dp_out = '0;
    logic                 dp_rst, dp_start, dp_ack, result_valid, busy, done, err;
    logic [WIDTH-1:0]     result;
    logic [1:0]           err_code;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    logic [WIDTH-1:0] exp_tab [5] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};

    fib_seq_ctrl #(
        .WIDTH(WIDTH), .RAIL_NUM(2), .CNT_W(CNT_W),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .count(count),
        .dp_rst(dp_rst), .dp_start(dp_start), .dp_ack(dp_ack), .dp_out(dp_out),
        .result(result), .result_valid(result_valid), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (result_valid) rv_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            SIG_RV:    return result_valid;
            SIG_ACK:   return dp_ack;
            SIG_START: return dp_start;
            default:   return err;
        endcase
    endfunction

    function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] w);
        logic [2*WIDTH-1:0] e;
        for (int i = 0; i < WIDTH; i++) begin
            e[2*i+1] = w[i];
            e[2*i]   = ~w[i];
        end
        return e;
    endfunction

    task automatic wait_for(input string tag, input int w, input logic v, input int budget,
                            output int n);
        n = 0;
        while (sig(w) !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(sig(w)), 32'(v));
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_dp_rst"},   32'(dp_rst),       32'd1);
        check_eq({tag, "_dp_start"}, 32'(dp_start),     32'd0);
        check_eq({tag, "_dp_ack"},   32'(dp_ack),       32'd0);
        check_eq({tag, "_result"},   32'(result),       32'd0);
        check_eq({tag, "_rv"},       32'(result_valid), 32'd0);
        check_eq({tag, "_busy"},     32'(busy),         32'd0);
        check_eq({tag, "_done"},     32'(done),         32'd0);
        check_eq({tag, "_err"},      32'(err),          32'd0);
        check_eq({tag, "_err_code"}, 32'(err_code),     32'd0);
    endtask

    task automatic do_go(input int c);
        @(negedge clk);
        go    = 1'b1;
        count = CNT_W'(c);
        @(negedge clk);
        go = 1'b0;
    endtask

    // Datapath model: emits Fibonacci words and completes the four-phase handshake
    task automatic serve(input int n, input bit chk_lat);
        logic [WIDTH-1:0] a, b, t;
        int lat;
        a = '0;
        b = 16'd1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            dp_out = enc(a);
            wait_for("rv_seen", SIG_RV, 1'b1, 50, lat);
            if (chk_lat && k == 0) check_eq("cap_latency", 32'(lat), 32'd4);
            check_eq("result", 32'(result), 32'(exp_tab[k]));
            check_eq("ack_with_rv", 32'(dp_ack), 32'd1);
            @(negedge clk);
            dp_out = '0;
            wait_for("ack_fall", SIG_ACK, 1'b0, 50, lat);
            if (chk_lat && k == 0) check_eq("null_latency", 32'(lat), 32'd4);
            t = a + b;
            a = b;
            b = t;
        end
    endtask

    initial begin
        int lat;
        int base;

        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b1;
        @(negedge clk);

        // Zero-length run goes straight to DONE without touching the datapath
        base = rv_cnt;
        do_go(0);
        check_eq("z_done",   32'(done),     32'd1);
        check_eq("z_dp_rst", 32'(dp_rst),   32'd1);
        check_eq("z_start",  32'(dp_start), 32'd0);
        check_eq("z_busy",   32'(busy),     32'd0);
        repeat (5) @(negedge clk);
        check_eq("z_rv_cnt", 32'(rv_cnt - base), 32'd0);

        // Five-result run with reset/start timing
        base = rv_cnt;
        do_go(5);
        check_eq("r5_busy",   32'(busy),   32'd1);
        check_eq("r5_dp_rst", 32'(dp_rst), 32'd1);
        check_eq("r5_done",   32'(done),   32'd0);
        repeat (RST_CYCLES - 1) @(negedge clk);
        check_eq("r5_start_early", 32'(dp_start), 32'd0);
        check_eq("r5_rst_early",   32'(dp_rst),   32'd1);
        @(negedge clk);
        check_eq("r5_start_rise", 32'(dp_start), 32'd1);
        check_eq("r5_rst_fall",   32'(dp_rst),   32'd0);
        serve(5, 1'b1);
        check_eq("r5_done_end",  32'(done),     32'd1);
        check_eq("r5_start_end", 32'(dp_start), 32'd0);
        check_eq("r5_busy_end",  32'(busy),     32'd0);
        check_eq("r5_rv_cnt",    32'(rv_cnt - base), 32'd5);

        // Illegal 11 code on bit 3
        base = rv_cnt;
        do_go(1);
        check_eq("il_done_clr", 32'(done), 32'd0);
        wait_for("il_start", SIG_START, 1'b1, 20, lat);
        @(negedge clk);
        dp_out = enc(16'h0000);
        dp_out[7:6] = 2'b11;
        wait_for("il_err", SIG_ERR, 1'b1, 20, lat);
        check_eq("il_code",   32'(err_code), 32'd2);
        check_eq("il_dp_rst", 32'(dp_rst),   32'd1);
        check_eq("il_dp_ack", 32'(dp_ack),   32'd0);
        check_eq("il_start0", 32'(dp_start), 32'd0);
        check_eq("il_busy",   32'(busy),     32'd0);
        check_eq("il_rv_cnt", 32'(rv_cnt - base), 32'd0);
        dp_out = '0;

        // Datapath never returns to null after the first capture
        do_go(2);
        check_eq("to_err_clr",  32'(err),      32'd0);
        check_eq("to_code_clr", 32'(err_code), 32'd0);
        wait_for("to_start", SIG_START, 1'b1, 20, lat);
        @(negedge clk);
        dp_out = enc(16'h0000);
        wait_for("to_rv", SIG_RV, 1'b1, 20, lat);
`ifdef FIB_SEQ_TIMEOUT_EN
        wait_for("to_err", SIG_ERR, 1'b1, 40, lat);
        check_eq("to_latency", 32'(lat),      32'(TIMEOUT));
        check_eq("to_code",    32'(err_code), 32'd1);
        check_eq("to_ack",     32'(dp_ack),   32'd0);
`else
        repeat (1000) @(negedge clk);
        check_eq("nto_err",  32'(err),    32'd0);
        check_eq("nto_ack",  32'(dp_ack), 32'd1);
        check_eq("nto_busy", 32'(busy),   32'd1);
`endif
        dp_out = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("rst2");
        @(negedge clk);
        rst = 1'b1;

        // Abort a run after its second result, then run again
        do_go(5);
        wait_for("ab_start", SIG_START, 1'b1, 20, lat);
        serve(2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst = 1'b1;
        base = rv_cnt;
        do_go(3);
        wait_for("r3_start", SIG_START, 1'b1, 20, lat);
        serve(3, 1'b0);
        check_eq("r3_done",   32'(done), 32'd1);
        check_eq("r3_rv_cnt", 32'(rv_cnt - base), 32'd3);

        // Glitching rails, with a go pulse while busy
        base = rv_cnt;
        do_go(1);
        wait_for("gl_start", SIG_START, 1'b1, 20, lat);
        @(negedge clk);
        dp_out = enc(16'h1234);
        @(negedge clk);
        dp_out = enc(16'hBEEF);
        go     = 1'b1;
        count  = '0;
        @(negedge clk);
        dp_out = enc(16'h7A5C);
        go     = 1'b0;
        @(negedge clk);
        dp_out = enc(16'h0001);
        @(negedge clk);
        dp_out = enc(16'h0055);
        wait_for("gl_rv", SIG_RV, 1'b1, 20, lat);
        check_eq("gl_result", 32'(result), 32'h0055);
        check_eq("gl_done0",  32'(done),   32'd0);
        check_eq("gl_busy",   32'(busy),   32'd1);
        @(negedge clk);
        dp_out = '0;
        wait_for("gl_ack_fall", SIG_ACK, 1'b0, 20, lat);
        check_eq("gl_done",   32'(done),   32'd1);
        check_eq("gl_rv_cnt", 32'(rv_cnt - base), 32'd1);
        check_eq("gl_hold",   32'(result), 32'h0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
